// File: rtl/break_step_controller.sv
// break_step_controller: debug run/halt/step controller with a PC breakpoint and an enabled-cycle counter.
module break_step_controller #(
  parameter int PC_WIDTH    = 8,
  parameter int STEP_WIDTH  = 8,
  parameter int CYCLE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   isResetN,
  input  logic                   runRequest,
  input  logic                   haltRequest,
  input  logic                   stepRequest,
  input  logic [STEP_WIDTH-1:0]  stepCount,
  input  logic                   breakEnable,
  input  logic [PC_WIDTH-1:0]    breakAddress,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   cpuEnable,
  output logic [1:0]             state,
  output logic                   isHalted,
  output logic                   breakHit,
  output logic [STEP_WIDTH-1:0]  stepsRemaining,
  output logic [CYCLE_WIDTH-1:0] cycleCount
);
  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BRK} state_e;
  state_e                 state_q;
  logic                   armed_q, hit_q;
  logic [STEP_WIDTH-1:0]  steps_q;
  logic [CYCLE_WIDTH-1:0] cycle_q;
  logic                   active, break_match, step_ok;
  assign active      = state_q == S_RUN || state_q == S_STEP;
  assign break_match = breakEnable && pc == breakAddress && armed_q && active;
  assign step_ok     = stepRequest && stepCount != '0;
  assign cpuEnable   = active && !break_match;
  assign isHalted    = !active;
  assign state       = state_q;
  assign breakHit    = hit_q;
  assign stepsRemaining = steps_q;
  assign cycleCount  = cycle_q;
  // armed stays low for the first enabled cycle after entry so a resume at the breakpoint PC executes it
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state_q <= S_HALT;
      armed_q <= 1'b0;
      hit_q   <= 1'b0;
      steps_q <= '0;
      cycle_q <= '0;
    end else begin
      if (cpuEnable && cycle_q != '1) cycle_q <= cycle_q + 1'b1;
      if (cpuEnable) armed_q <= 1'b1;
      if (haltRequest) begin
        state_q <= S_HALT;
        if (active) steps_q <= '0;
      end else if (break_match) begin
        state_q <= S_BRK;
        hit_q   <= 1'b1;
      end else if (runRequest && state_q != S_RUN) begin
        state_q <= S_RUN;
        steps_q <= '0;
        armed_q <= 1'b0;
        hit_q   <= hit_q && state_q != S_BRK;
      end else if (step_ok && !active) begin
        state_q <= S_STEP;
        steps_q <= stepCount;
        armed_q <= 1'b0;
        hit_q   <= hit_q && state_q != S_BRK;
      end else if (state_q == S_STEP && cpuEnable) begin
        steps_q <= steps_q - 1'b1;
        if (steps_q == STEP_WIDTH'(1)) state_q <= S_HALT;
      end
    end
  end
endmodule

// File: tb/tb_break_step_controller.sv
// tb_break_step_controller: directed vectors with hand-computed expectations for break_step_controller.
module tb_break_step_controller;
  logic        clock = 0, isResetN = 0;
  logic        runRequest = 0, haltRequest = 0, stepRequest = 0, breakEnable = 0;
  logic [7:0]  stepCount = 0, breakAddress = 0, pc = 0;
  logic        cpuEnable, isHalted, breakHit;
  logic [1:0]  state;
  logic [7:0]  stepsRemaining;
  logic [15:0] cycleCount;
  int vectors = 0, miscompares = 0;

  break_step_controller dut (
    .clock(clock), .isResetN(isResetN), .runRequest(runRequest), .haltRequest(haltRequest),
    .stepRequest(stepRequest), .stepCount(stepCount), .breakEnable(breakEnable),
    .breakAddress(breakAddress), .pc(pc), .cpuEnable(cpuEnable), .state(state),
    .isHalted(isHalted), .breakHit(breakHit), .stepsRemaining(stepsRemaining), .cycleCount(cycleCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_state", state, 0);
    chk("rst_en", cpuEnable, 0);
    chk("rst_hit", breakHit, 0);
    chk("rst_steps", stepsRemaining, 0);
    chk("rst_cycles", cycleCount, 0);
    chk("rst_halted", isHalted, 1);
    cyc();
    isResetN = 1;
    // free run for 10 cycles
    runRequest = 1; cyc(); runRequest = 0;
    chk("run_state", state, 1);
    for (int i = 0; i < 10; i++) begin
      chk("run_en", cpuEnable, 1);
      cyc();
    end
    chk("run_cycles", cycleCount, 10);
    haltRequest = 1; #1;
    chk("halt_cur_en", cpuEnable, 1);
    cyc(); haltRequest = 0;
    chk("halt_state", state, 0);
    chk("halt_cycles", cycleCount, 11);
    // step burst of 3
    stepRequest = 1; stepCount = 3; cyc(); stepRequest = 0;
    chk("step_state", state, 2);
    chk("step_rem3", stepsRemaining, 3);
    chk("step_en", cpuEnable, 1);
    cyc(); chk("step_rem2", stepsRemaining, 2);
    cyc(); chk("step_rem1", stepsRemaining, 1);
    cyc(); chk("step_rem0", stepsRemaining, 0);
    chk("step_done", state, 0);
    chk("step_off", cpuEnable, 0);
    chk("step_cycles", cycleCount, 14);
    // breakpoint at 0x05
    breakEnable = 1; breakAddress = 8'h05; pc = 8'h03;
    runRequest = 1; cyc(); runRequest = 0;
    cyc(); pc = 8'h04;
    cyc(); pc = 8'h05; #1;
    chk("bp_en", cpuEnable, 0);
    cyc();
    chk("bp_state", state, 3);
    chk("bp_hit", breakHit, 1);
    chk("bp_halted", isHalted, 1);
    cyc();
    chk("bp_cycles", cycleCount, 16);
    chk("bp_hold_en", cpuEnable, 0);
    // resume at the breakpoint PC
    runRequest = 1; cyc(); runRequest = 0;
    chk("res_state", state, 1);
    chk("res_hit", breakHit, 0);
    chk("res_en", cpuEnable, 1);
    cyc(); pc = 8'h06; #1;
    chk("res_pc6_en", cpuEnable, 1);
    cyc(); pc = 8'h05; #1;
    chk("rebp_en", cpuEnable, 0);
    cyc();
    chk("rebp_state", state, 3);
    chk("rebp_cycles", cycleCount, 18);
    // halt beats break and run in one RUN cycle
    runRequest = 1; cyc(); runRequest = 0;
    cyc(); pc = 8'h06;
    cyc(); pc = 8'h05; haltRequest = 1; runRequest = 1;
    cyc(); haltRequest = 0; runRequest = 0;
    chk("pri_state", state, 0);
    chk("pri_hit", breakHit, 0);
    chk("pri_cycles", cycleCount, 20);
    breakEnable = 0; pc = 0;
    runRequest = 1; stepRequest = 1; stepCount = 2; cyc(); runRequest = 0; stepRequest = 0;
    chk("pri_run_step", state, 1);
    haltRequest = 1; cyc(); haltRequest = 0;
    chk("pri_halt_cycles", cycleCount, 21);
    // asynchronous reset mid-step
    stepRequest = 1; stepCount = 4; cyc(); stepRequest = 0;
    cyc(); cyc();
    chk("mid_rem", stepsRemaining, 2);
    #2 isResetN = 0; #1;
    chk("arst_en", cpuEnable, 0);
    chk("arst_rem", stepsRemaining, 0);
    chk("arst_state", state, 0);
    chk("arst_cycles", cycleCount, 0);
    runRequest = 1; cyc(); runRequest = 0;
    chk("arst_ignore", state, 0);
    isResetN = 1;
    stepRequest = 1; stepCount = 0; cyc(); stepRequest = 0;
    chk("step0_ignore", state, 0);
    // run from STEP, then saturate the cycle counter
    stepRequest = 1; stepCount = 5; cyc(); stepRequest = 0;
    chk("s2r_step", stepsRemaining, 5);
    runRequest = 1; cyc(); runRequest = 0;
    chk("s2r_state", state, 1);
    chk("s2r_rem", stepsRemaining, 0);
    repeat (65540) cyc();
    chk("sat_cycles", cycleCount, 16'hFFFF);
    chk("sat_state", state, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/break_step_controller.md
BREAK_STEP_CONTROLLER -- requirements
Module: break_step_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: width of pc and breakAddress.
REQ-002 SHALL have parameter STEP_WIDTH, default 8: width of stepCount and stepsRemaining.
REQ-003 SHALL have parameter CYCLE_WIDTH, default 16: width of cycleCount.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port isResetN, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port runRequest, input, 1: request free-running execution.
REQ-007 SHALL have port haltRequest, input, 1: request a stop.
REQ-008 SHALL have port stepRequest, input, 1: request execution of stepCount instructions.
REQ-009 SHALL have port stepCount, input, STEP_WIDTH: number of instructions to step, sampled when stepRequest is accepted.
REQ-010 SHALL have port breakEnable, input, 1: breakpoint compare enable.
REQ-011 SHALL have port breakAddress, input, PC_WIDTH: breakpoint PC.
REQ-012 SHALL have port pc, input, PC_WIDTH: current CPU program counter.
REQ-013 SHALL have port cpuEnable, output, 1: CPU clock enable; the CPU executes one instruction per cycle in which it is high.
REQ-014 SHALL have port state, output, 2: HALT=0, RUN=1, STEP=2, BREAK=3.
REQ-015 SHALL have port isHalted, output, 1: high in HALT or BREAK.
REQ-016 SHALL have port breakHit, output, 1: sticky breakpoint flag.
REQ-017 SHALL have port stepsRemaining, output, STEP_WIDTH: instructions left in the current step burst.
REQ-018 SHALL have port cycleCount, output, CYCLE_WIDTH: count of enabled cycles.

Function
REQ-019 SHALL leave reset in HALT, with cpuEnable=0, breakHit=0, stepsRemaining=0 and cycleCount=0.
REQ-020 SHALL compute cpuEnable combinationally as (state==RUN or state==STEP) and not breakMatch.
REQ-021 SHALL define breakMatch as breakEnable & (pc==breakAddress) & armed & (state is RUN or STEP).
REQ-022 SHALL clear armed on every transition into RUN or STEP and set armed after the first enabled cycle, so resuming at the breakpoint PC executes that instruction.
REQ-023 SHALL apply request priority haltRequest > breakMatch > runRequest > stepRequest in every state.
REQ-024 In HALT, runRequest SHALL move to RUN on the next cycle.
REQ-025 In HALT, stepRequest with stepCount!=0 SHALL move to STEP and load stepsRemaining=stepCount.
REQ-026 stepRequest with stepCount==0 SHALL be ignored, with no state change.
REQ-027 In RUN or STEP, haltRequest SHALL move to HALT next cycle and clear stepsRemaining to 0; the current-cycle instruction still executes if cpuEnable=1.
REQ-028 In RUN or STEP, breakMatch SHALL force cpuEnable=0 in the same cycle, so the instruction at breakAddress is not executed.
REQ-029 On breakMatch, the block SHALL move to BREAK next cycle and set breakHit=1; stepsRemaining SHALL hold its value.
REQ-030 In STEP, each enabled cycle SHALL decrement stepsRemaining.
REQ-031 In STEP, an enabled cycle with stepsRemaining==1 SHALL move to HALT with stepsRemaining=0.
REQ-032 In RUN, runRequest and stepRequest SHALL be ignored.
REQ-033 In STEP, runRequest SHALL move to RUN and clear stepsRemaining; stepRequest SHALL be ignored.
REQ-034 BREAK SHALL keep cpuEnable=0.
REQ-035 In BREAK, runRequest SHALL move to RUN and stepRequest (stepCount!=0) SHALL move to STEP; either SHALL clear breakHit on that edge.
REQ-036 In BREAK, haltRequest SHALL move to HALT with breakHit retained.
REQ-037 cycleCount SHALL increment on every cycle with cpuEnable=1, saturating at all-ones.
REQ-038 cycleCount SHALL not wrap and SHALL clear only on reset.
REQ-039 All outputs except cpuEnable and isHalted SHALL be registered.

Reset
REQ-040 Asserting isResetN low SHALL immediately, without a clock edge, force the REQ-019 values and state=HALT, armed=0, including mid-RUN or mid-STEP.
REQ-041 While isResetN is low, all requests SHALL be ignored.
REQ-042 The first request SHALL be honoured on the first rising edge after deassertion.

Verification
REQ-043 Reset, then pulse runRequest for 1 cycle, hold 10 cycles -> state=RUN, cpuEnable=1 for 10 cycles, cycleCount=10.
REQ-044 From HALT, stepRequest with stepCount=3 -> exactly 3 enabled cycles, stepsRemaining 3,2,1,0, then state=HALT.
REQ-045 breakEnable=1, breakAddress=0x05, RUN with pc reaching 0x05 -> cpuEnable=0 in that cycle, state=BREAK, breakHit=1, cycleCount stops.
REQ-046 From BREAK at pc=0x05, runRequest -> breakHit=0, first cycle enabled (no re-trigger); breaks again only on a later pc=0x05.
REQ-047 haltRequest, runRequest and breakMatch in the same RUN cycle -> HALT wins, breakHit stays 0; in HALT, run+step together -> RUN.
REQ-048 Mid-STEP with stepsRemaining=2, pull isResetN low between edges -> cpuEnable=0 and stepsRemaining=0 immediately; stepCount=0 request afterwards -> remains HALT.
